// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the data-side BRAM port arbiter
// Holds the memOp/memSize encodings and the arbiter FSM state type.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_DISABLE   = 2'b00,
        MEM_READ_SEXT = 2'b01,
        MEM_READ_ZEXT = 2'b10,
        MEM_WRITE     = 2'b11
    } mem_op_t;

    // 2'b11 is deliberately left unnamed: it is an illegal size
    typedef enum logic [1:0] {
        BYTE     = 2'b00,
        HALFWORD = 2'b01,
        WORD     = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response handshake of one requester of the BRAM port
// master: requester side (drives req_valid/addr/memOp/memSize/wdata)
// slave:  arbiter side (drives req_ready/rsp_valid/rsp_err/rdata)
interface mem_port_arbiter_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr;
    logic [1:0]  memOp;
    logic [1:0]  memSize;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rdata;

    modport master (
        output req_valid, addr, memOp, memSize, wdata,
        input  req_ready, rsp_valid, rsp_err, rdata
    );

    modport slave (
        input  req_valid, addr, memOp, memSize, wdata,
        output req_ready, rsp_valid, rsp_err, rdata
    );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane alignment for stores, extraction/extension for loads
// i_st_*: store side (current request): lane, size, data -> o_st_we, o_st_din, o_st_err
// i_ld_*: load side (registered request): lane, size, op, BRAM data -> o_ld_data
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_st_lane,
    input  logic [1:0]  i_st_size,
    input  logic [31:0] i_st_wdata,
    output logic [3:0]  o_st_we,
    output logic [31:0] o_st_din,
    output logic        o_st_err,
    input  logic [1:0]  i_ld_lane,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_op,
    input  logic [31:0] i_ld_dout,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shift;
    logic        w_sext;

    always_comb begin
        o_st_we    = i_st_size == BYTE     ? 4'b0001 << i_st_lane :
                     i_st_size == HALFWORD ? 4'b0011 << {i_st_lane[1], 1'b0} : 4'b1111;
        o_st_din   = i_st_size == BYTE     ? {4{i_st_wdata[7:0]}} :
                     i_st_size == HALFWORD ? {2{i_st_wdata[15:0]}} : i_st_wdata;
        o_st_err   = i_st_size == 2'b11
                   | (i_st_size == HALFWORD & i_st_lane[0])
                   | (i_st_size == WORD & |i_st_lane);
        // bring the addressed byte/halfword down to bit 0 before extending
        w_ld_shift = i_ld_dout >> (i_ld_size == BYTE     ? {i_ld_lane, 3'b000} :
                                   i_ld_size == HALFWORD ? {i_ld_lane[1], 4'b0000} : 5'd0);
        w_sext     = i_ld_op == MEM_READ_SEXT;
        o_ld_data  = i_ld_size == BYTE     ? {{24{w_sext & w_ld_shift[7]}}, w_ld_shift[7:0]} :
                     i_ld_size == HALFWORD ? {{16{w_sext & w_ld_shift[15]}}, w_ld_shift[15:0]} :
                     w_ld_shift;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequencer/arbiter sharing data BRAM port B between CPU and loader
// clk, reset   : clock, synchronous active-high reset
// cpu, ldr     : request/response ports (mem_port_arbiter_if.slave), cpu wins by default
// bram_*       : BRAM port B (en, byte we, word addr, din, dout after READ_LATENCY)
// MEM_ARB_RR_EN: when defined, round-robin arbitration replaces fixed cpu priority
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int READ_LATENCY = 1
)(
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     cpu,
    mem_port_arbiter_if.slave     ldr,
    output logic                  bram_en,
    output logic [3:0]            bram_we,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [31:0]           bram_din,
    input  logic [31:0]           bram_dout
);

    localparam logic CNT_INIT = 1'(READ_LATENCY - 1);

    state_t      r_state, w_next;
    logic        r_owner_ldr, r_rsp_valid, r_rsp_err, r_cnt;
    logic [31:0] r_rdata;
    logic [1:0]  r_lane, r_size, r_op;
    logic        w_open, w_ldr_pri, w_gnt_cpu, w_gnt_ldr, w_accept;
    logic        w_err, w_fail, w_access, w_read, w_write;
    logic [31:0] w_addr, w_wdata, w_din, w_ld_data;
    logic [1:0]  w_op, w_size;
    logic [3:0]  w_we;
    logic        w_unused;

`ifdef MEM_ARB_RR_EN
    // set when cpu was granted last, so ldr wins the next contention
    logic r_ldr_pri;
    always_ff @(posedge clk) begin
        if (reset) r_ldr_pri <= 1'b0;
        else if (w_accept) r_ldr_pri <= w_gnt_cpu;
    end
    assign w_ldr_pri = r_ldr_pri;
`else
    assign w_ldr_pri = 1'b0;
`endif

    always_comb begin
        w_open    = !reset & r_state != WAIT;
        w_gnt_cpu = w_open & cpu.req_valid & (!ldr.req_valid | !w_ldr_pri);
        w_gnt_ldr = w_open & ldr.req_valid & !w_gnt_cpu;
        w_accept  = w_gnt_cpu | w_gnt_ldr;
        w_addr    = w_gnt_ldr ? ldr.addr    : cpu.addr;
        w_wdata   = w_gnt_ldr ? ldr.wdata   : cpu.wdata;
        w_op      = w_gnt_ldr ? ldr.memOp   : cpu.memOp;
        w_size    = w_gnt_ldr ? ldr.memSize : cpu.memSize;
        // a no-op is never an error, whatever its size field says
        w_fail    = w_op != MEM_DISABLE & w_err;
        w_access  = w_accept & w_op != MEM_DISABLE & !w_err;
        w_write   = w_access & w_op == MEM_WRITE;
        w_read    = w_access & w_op != MEM_WRITE;
    end

    mem_lane_align u_align (
        .i_st_lane  (w_addr[1:0]),
        .i_st_size  (w_size),
        .i_st_wdata (w_wdata),
        .o_st_we    (w_we),
        .o_st_din   (w_din),
        .o_st_err   (w_err),
        .i_ld_lane  (r_lane),
        .i_ld_size  (r_size),
        .i_ld_op    (r_op),
        .i_ld_dout  (bram_dout),
        .o_ld_data  (w_ld_data)
    );

    assign bram_en   = w_access;
    assign bram_we   = w_write ? w_we : 4'b0000;
    assign bram_addr = w_access ? w_addr[ADDR_W+1:2] : '0;
    assign bram_din  = w_write ? w_din : '0;
    assign w_unused  = &{1'b0, w_addr[31:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == WAIT) w_next = r_cnt == 1'b0 ? RESP : WAIT;
        else w_next = w_read ? WAIT : w_accept ? RESP : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rdata     <= '0;
            r_owner_ldr <= 1'b0;
            r_lane      <= '0;
            r_size      <= '0;
            r_op        <= '0;
            r_cnt       <= 1'b0;
        end else begin
            r_rsp_valid <= w_next == RESP;
            if (w_accept) begin
                r_owner_ldr <= w_gnt_ldr;
                r_lane      <= w_addr[1:0];
                r_size      <= w_size;
                r_op        <= w_op;
                r_cnt       <= CNT_INIT;
                r_rsp_err   <= w_fail;
                r_rdata     <= '0;
            end else if (r_state == WAIT) begin
                // the capture on the last WAIT cycle is the one that is returned
                r_cnt       <= r_cnt - 1'b1;
                r_rdata     <= w_ld_data;
                r_rsp_err   <= 1'b0;
            end
        end
    end

    assign cpu.req_ready = w_gnt_cpu;
    assign ldr.req_ready = w_gnt_ldr;
    assign cpu.rsp_valid = r_rsp_valid & !r_owner_ldr;
    assign ldr.rsp_valid = r_rsp_valid & r_owner_ldr;
    assign cpu.rsp_err   = cpu.rsp_valid & r_rsp_err;
    assign ldr.rsp_err   = ldr.rsp_valid & r_rsp_err;
    assign cpu.rdata     = cpu.rsp_valid ? r_rdata : '0;
    assign ldr.rdata     = ldr.rsp_valid ? r_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter (READ_LATENCY 1 and 2)
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int AW = 15;

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [1:0]  sz;
        logic [31:0] ad;
        logic [31:0] wd;
    } req_t;

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sz;
        logic [31:0] ad;
        logic [31:0] wd;
        logic        en;
        logic [3:0]  we;
        logic [31:0] baddr;
        logic [31:0] din;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        int          due;
        logic        own_ldr;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    mem_port_arbiter_if a_cpu(), a_ldr(), b_cpu(), b_ldr();
    logic          a_en, b_en;
    logic [3:0]    a_we, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [31:0]   a_din, b_din, a_dout, b_dout, b_q1;
    logic [31:0]   mem_a [64];
    logic [31:0]   mem_b [64];

    mem_port_arbiter #(.ADDR_W(AW), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(rst_a), .cpu(a_cpu), .ldr(a_ldr),
        .bram_en(a_en), .bram_we(a_we), .bram_addr(a_addr), .bram_din(a_din), .bram_dout(a_dout)
    );

    mem_port_arbiter #(.ADDR_W(AW), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(rst_b), .cpu(b_cpu), .ldr(b_ldr),
        .bram_en(b_en), .bram_we(b_we), .bram_addr(b_addr), .bram_din(b_din), .bram_dout(b_dout)
    );

    // BRAM A: 1-cycle latency, cleared whenever dut_a is reset
    always @(posedge clk) begin
        if (rst_a) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= '0;
            a_dout <= '0;
        end else if (a_en) begin
            a_dout <= mem_a[a_addr[5:0]];
            for (int i = 0; i < 4; i++) if (a_we[i]) mem_a[a_addr[5:0]][8*i+:8] <= a_din[8*i+:8];
        end
    end

    // BRAM B: 2-cycle latency, contents survive reset
    always @(posedge clk) begin
        if (b_en) begin
            b_q1 <= mem_b[b_addr[5:0]];
            for (int i = 0; i < 4; i++) if (b_we[i]) mem_b[b_addr[5:0]][8*i+:8] <= b_din[8*i+:8];
        end
        b_dout <= b_q1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv_a(input req_t c, input req_t l);
        a_cpu.req_valid = c.v; a_cpu.memOp = c.op; a_cpu.memSize = c.sz; a_cpu.addr = c.ad; a_cpu.wdata = c.wd;
        a_ldr.req_valid = l.v; a_ldr.memOp = l.op; a_ldr.memSize = l.sz; a_ldr.addr = l.ad; a_ldr.wdata = l.wd;
    endtask

    task automatic drv_b(input req_t c, input req_t l);
        b_cpu.req_valid = c.v; b_cpu.memOp = c.op; b_cpu.memSize = c.sz; b_cpu.addr = c.ad; b_cpu.wdata = c.wd;
        b_ldr.req_valid = l.v; b_ldr.memOp = l.op; b_ldr.memSize = l.sz; b_ldr.addr = l.ad; b_ldr.wdata = l.wd;
    endtask

    task automatic a_reset();
        req_t z;
        z = '{default: '0};
        @(posedge clk); #1;
        rst_a = 1'b1;
        drv_a(z, z);
        @(posedge clk); #1;
        rst_a = 1'b0;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic model_err(input req_t r);
        if (r.op == 2'b00) return 1'b0;
        return r.sz == 2'b11 || (r.sz == 2'b01 && r.ad[0]) || (r.sz == 2'b10 && r.ad[1:0] != 2'b00);
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.v  = 1'b1;
        r.op = 2'($urandom_range(0, 3));
        r.sz = $urandom_range(0, 9) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
        r.ad = 32'($urandom_range(0, 255));
        r.wd = $urandom;
        return r;
    endfunction

    vec_t        tv [16];
    req_t        z, c, l, r;
    exp_t        q [$];
    exp_t        e;
    logic [31:0] mm [64];
    logic [3:0]  exp_cpu;

    initial begin
        z = '{default: '0};
        drv_a(z, z);
        drv_b(z, z);

        tv[0]  = '{MEM_WRITE,     BYTE,     32'h06, 32'h0000_00A5, 1'b1, 4'b0100, 32'd1, 32'hA5A5_A5A5, 1'b0, 32'h0};
        tv[1]  = '{MEM_WRITE,     WORD,     32'h10, 32'h8000_F081, 1'b1, 4'b1111, 32'd4, 32'h8000_F081, 1'b0, 32'h0};
        tv[2]  = '{MEM_READ_SEXT, HALFWORD, 32'h12, 32'h0,         1'b1, 4'b0000, 32'd4, 32'h0,         1'b0, 32'hFFFF_8000};
        tv[3]  = '{MEM_READ_ZEXT, BYTE,     32'h10, 32'h0,         1'b1, 4'b0000, 32'd4, 32'h0,         1'b0, 32'h0000_0081};
        tv[4]  = '{MEM_WRITE,     HALFWORD, 32'h03, 32'h0000_FFFF, 1'b0, 4'b0000, 32'd0, 32'h0,         1'b1, 32'h0};
        tv[5]  = '{MEM_READ_ZEXT, WORD,     32'h00, 32'h0,         1'b1, 4'b0000, 32'd0, 32'h0,         1'b0, 32'h0};
        tv[6]  = '{MEM_READ_ZEXT, WORD,     32'h04, 32'h0,         1'b1, 4'b0000, 32'd1, 32'h0,         1'b0, 32'h00A5_0000};
        tv[7]  = '{MEM_READ_SEXT, BYTE,     32'h11, 32'h0,         1'b1, 4'b0000, 32'd4, 32'h0,         1'b0, 32'hFFFF_FFF0};
        tv[8]  = '{MEM_READ_ZEXT, HALFWORD, 32'h10, 32'h0,         1'b1, 4'b0000, 32'd4, 32'h0,         1'b0, 32'h0000_F081};
        tv[9]  = '{MEM_READ_SEXT, WORD,     32'h12, 32'h0,         1'b0, 4'b0000, 32'd0, 32'h0,         1'b1, 32'h0};
        tv[10] = '{MEM_READ_SEXT, 2'b11,    32'h10, 32'h0,         1'b0, 4'b0000, 32'd0, 32'h0,         1'b1, 32'h0};
        tv[11] = '{MEM_DISABLE,   WORD,     32'h10, 32'h1234_5678, 1'b0, 4'b0000, 32'd0, 32'h0,         1'b0, 32'h0};
        tv[12] = '{MEM_WRITE,     HALFWORD, 32'h12, 32'h0000_1234, 1'b1, 4'b1100, 32'd4, 32'h1234_1234, 1'b0, 32'h0};
        tv[13] = '{MEM_READ_SEXT, WORD,     32'h10, 32'h0,         1'b1, 4'b0000, 32'd4, 32'h0,         1'b0, 32'h1234_F081};
        tv[14] = '{MEM_WRITE,     BYTE,     32'h13, 32'h0000_007E, 1'b1, 4'b1000, 32'd4, 32'h7E7E_7E7E, 1'b0, 32'h0};
        tv[15] = '{MEM_READ_SEXT, BYTE,     32'h13, 32'h0,         1'b1, 4'b0000, 32'd4, 32'h0,         1'b0, 32'h0000_007E};

        // reset: a valid request must not be granted while reset is high
        repeat (2) @(posedge clk);
        #1;
        c = '{1'b1, MEM_WRITE, WORD, 32'h0, 32'hFFFF_FFFF};
        drv_a(c, c);
        #1;
        chk("rst cpu_ready", 32'(a_cpu.req_ready), 32'd0);
        chk("rst ldr_ready", 32'(a_ldr.req_ready), 32'd0);
        chk("rst bram_en", 32'(a_en), 32'd0);
        chk("rst bram_we", 32'(a_we), 32'd0);
        drv_a(z, z);
        @(posedge clk); #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("rst cpu_rsp_valid", 32'(a_cpu.rsp_valid), 32'd0);
        chk("rst ldr_rsp_valid", 32'(a_ldr.rsp_valid), 32'd0);
        chk("rst cpu_rdata", a_cpu.rdata, 32'd0);
        chk("rst bram_addr", 32'(a_addr), 32'd0);
        chk("rst bram_din", a_din, 32'd0);

        // directed single cpu transactions, READ_LATENCY=1
        foreach (tv[i]) begin
            int lat;
            @(posedge clk); #1;
            c = '{1'b1, tv[i].op, tv[i].sz, tv[i].ad, tv[i].wd};
            drv_a(c, z);
            #1;
            chk($sformatf("v%0d cpu_ready", i), 32'(a_cpu.req_ready), 32'd1);
            chk($sformatf("v%0d ldr_ready", i), 32'(a_ldr.req_ready), 32'd0);
            chk($sformatf("v%0d bram_en", i), 32'(a_en), 32'(tv[i].en));
            chk($sformatf("v%0d bram_we", i), 32'(a_we), 32'(tv[i].we));
            chk($sformatf("v%0d bram_addr", i), 32'(a_addr), tv[i].baddr);
            chk($sformatf("v%0d bram_din", i), a_din, tv[i].din);
            lat = (tv[i].en && tv[i].op != MEM_WRITE) ? 2 : 1;
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk); #1;
                drv_a(z, z);
                #1;
                chk($sformatf("v%0d idle bram_en", i), 32'(a_en), 32'd0);
                chk($sformatf("v%0d cpu_rsp_valid c%0d", i, k), 32'(a_cpu.rsp_valid), 32'(k == lat));
                chk($sformatf("v%0d ldr_rsp_valid c%0d", i, k), 32'(a_ldr.rsp_valid), 32'd0);
                if (k == lat) begin
                    chk($sformatf("v%0d rsp_err", i), 32'(a_cpu.rsp_err), 32'(tv[i].err));
                    chk($sformatf("v%0d rdata", i), a_cpu.rdata, tv[i].rd);
                end
            end
        end

        // contention: both valid for four back-to-back grants
        a_reset();
`ifdef MEM_ARB_RR_EN
        exp_cpu = 4'b0101;
`else
        exp_cpu = 4'b1111;
`endif
        c = '{1'b1, MEM_DISABLE, WORD, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drv_a(c, c);
            #1;
            chk($sformatf("grant%0d cpu_ready", i), 32'(a_cpu.req_ready), 32'(exp_cpu[i]));
            chk($sformatf("grant%0d ldr_ready", i), 32'(a_ldr.req_ready), 32'(!exp_cpu[i]));
            if (i > 0) chk($sformatf("grant%0d cpu_rsp_valid", i), 32'(a_cpu.rsp_valid), 32'(exp_cpu[i-1]));
        end
        @(posedge clk); #1;
        drv_a(z, z);
        #1;
        chk("grant3 ldr_rsp_valid", 32'(a_ldr.rsp_valid), 32'(!exp_cpu[3]));

        // randomized traffic against a cycle-count reference model
        a_reset();
        begin
            int   next_free, cyc;
            logic ldr_pri, gc, gl, ev_c, ev_l, e_err, err, acc, rd_op;
            logic [31:0] e_rd, val, mask, din, word;
            logic [3:0]  we;
            int   nb, lane;
            for (int i = 0; i < 64; i++) mm[i] = '0;
            next_free = 0;
            ldr_pri = 1'b0;
            c = z;
            l = z;
            for (cyc = 0; cyc < 400; cyc++) begin
                @(posedge clk); #1;
                if (cyc < 390 && !c.v && $urandom_range(0, 2) != 0) c = rand_req();
                if (cyc < 390 && !l.v && $urandom_range(0, 2) != 0) l = rand_req();
                drv_a(c, l);
                #1;
                ev_c = 1'b0; ev_l = 1'b0; e_err = 1'b0; e_rd = '0;
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    ev_c = !e.own_ldr; ev_l = e.own_ldr; e_err = e.err; e_rd = e.rd;
                end
                chk("rnd cpu_rsp_valid", 32'(a_cpu.rsp_valid), 32'(ev_c));
                chk("rnd cpu_rsp_err", 32'(a_cpu.rsp_err), 32'(ev_c & e_err));
                chk("rnd cpu_rdata", a_cpu.rdata, ev_c ? e_rd : 32'h0);
                chk("rnd ldr_rsp_valid", 32'(a_ldr.rsp_valid), 32'(ev_l));
                chk("rnd ldr_rsp_err", 32'(a_ldr.rsp_err), 32'(ev_l & e_err));
                chk("rnd ldr_rdata", a_ldr.rdata, ev_l ? e_rd : 32'h0);
                gc = cyc >= next_free && c.v && (!l.v || !ldr_pri);
                gl = cyc >= next_free && l.v && !gc;
                chk("rnd cpu_ready", 32'(a_cpu.req_ready), 32'(gc));
                chk("rnd ldr_ready", 32'(a_ldr.req_ready), 32'(gl));
                we = '0; din = '0; val = '0; acc = 1'b0; rd_op = 1'b0; err = 1'b0;
                if (gc || gl) begin
                    r = gc ? c : l;
                    err = model_err(r);
                    acc = r.op != 2'b00 && !err;
                    rd_op = acc && r.op != 2'b11;
                    nb = nbytes(r.sz);
                    lane = int'(r.ad[1:0]);
                    word = mm[r.ad[7:2]];
                    if (acc && r.op == 2'b11) begin
                        we = 4'(((1 << nb) - 1) << lane);
                        for (int b = 0; b < 4; b++) din[8*b+:8] = r.wd[8*(b % nb)+:8];
                        for (int b = 0; b < 4; b++) if (we[b]) mm[r.ad[7:2]][8*b+:8] = din[8*b+:8];
                    end
                    if (rd_op) begin
                        mask = nb == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
                        val = (word >> (8 * lane)) & mask;
                        if (r.op == 2'b01 && val[8*nb-1]) val = val | ~mask;
                    end
                    q.push_back('{cyc + (rd_op ? 2 : 1), gl, err, val});
                    next_free = cyc + (rd_op ? 2 : 1);
`ifdef MEM_ARB_RR_EN
                    ldr_pri = gc;
`endif
                    if (gc) c.v = 1'b0;
                    else l.v = 1'b0;
                end
                chk("rnd bram_en", 32'(a_en), 32'(acc));
                chk("rnd bram_we", 32'(a_we), 32'(we));
                chk("rnd bram_addr", 32'(a_addr), acc ? {26'd0, r.ad[7:2]} : 32'd0);
                chk("rnd bram_din", a_din, din);
            end
            drv_a(z, z);
            chk("rnd drain", 32'(q.size()), 32'd0);
        end

        // READ_LATENCY=2: preload, then a read dropped by reset, then a clean read
        @(posedge clk); #1;
        c = '{1'b1, MEM_WRITE, WORD, 32'h08, 32'hCAFE_1234};
        drv_b(c, z);
        #1;
        chk("b preload ready", 32'(b_cpu.req_ready), 32'd1);
        @(posedge clk); #1;
        drv_b(z, z);
        #1;
        chk("b preload rsp", 32'(b_cpu.rsp_valid), 32'd1);
        @(posedge clk); #1;
        l = '{1'b1, MEM_READ_ZEXT, WORD, 32'h08, 32'h0};
        drv_b(z, l);
        #1;
        chk("b ldr_ready T", 32'(b_ldr.req_ready), 32'd1);
        chk("b bram_en T", 32'(b_en), 32'd1);
        @(posedge clk); #1;
        drv_b(z, z);
        rst_b = 1'b1;
        #1;
        chk("b ldr_rsp T+1", 32'(b_ldr.rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        #1;
        chk("b rst ldr_rsp", 32'(b_ldr.rsp_valid), 32'd0);
        chk("b rst cpu_rsp", 32'(b_cpu.rsp_valid), 32'd0);
        chk("b rst rdata", b_ldr.rdata | b_cpu.rdata, 32'd0);
        chk("b rst err", 32'({b_ldr.rsp_err, b_cpu.rsp_err}), 32'd0);
        chk("b rst bram", 32'({b_en, b_we}) | 32'(b_addr) | b_din, 32'd0);
        @(posedge clk); #1;
        c = '{1'b1, MEM_READ_ZEXT, HALFWORD, 32'h0A, 32'h0};
        drv_b(c, z);
        #1;
        chk("b cpu_ready T+3", 32'(b_cpu.req_ready), 32'd1);
        chk("b bram_addr T+3", 32'(b_addr), 32'd2);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            drv_b(z, z);
            #1;
            chk($sformatf("b ldr_rsp c%0d", k), 32'(b_ldr.rsp_valid), 32'd0);
            chk($sformatf("b cpu_rsp c%0d", k), 32'(b_cpu.rsp_valid), 32'(k == 3));
            if (k == 3) chk("b cpu_rdata", b_cpu.rdata, 32'h0000_CAFE);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
